// File: rtl/cipher_pkg.sv
// Shared definitions for the cipher round sequencer.
//   seq_state_t    - control FSM state encoding (also visible on the debug port)
//   BLOCK_W        - width of a cipher block
//   RND_IDX_W      - width of the round index bus
//   TIMER_W        - width of the permutation status-wait timer
//   DEF_NUM_ROUNDS - default round passes per block
//   DEF_TIMEOUT    - default status-wait limit in cycles
package cipher_pkg;

  localparam int BLOCK_W        = 64;
  localparam int RND_IDX_W      = 4;
  localparam int TIMER_W        = 8;
  localparam int DEF_NUM_ROUNDS = 16;
  localparam int DEF_TIMEOUT    = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IP_START,
    S_IP_WAIT,
    S_ROUND,
    S_FP_START,
    S_FP_WAIT,
    S_DONE,
    S_ERROR
  } seq_state_t;

endpackage

// File: rtl/cipher_stage_timer.sv
// Status-wait timer for the permutation WAIT states.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - zero the count (issued in the START state ahead of a wait)
//   en        - one status-low wait cycle elapsed; count it
//   expired   - this counted cycle brings the count to TIMEOUT
module cipher_stage_timer
  import cipher_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + TIMER_W'(1);
    end
  end

  // Flagged one cycle early so the FSM leaves the wait on the edge where
  // the count would reach TIMEOUT.
  assign expired = en && (count == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/cipher_round_sequencer.sv
// Top-level control FSM of the encrypter. Accepts one 64-bit block, runs it
// through the initial permutation, NUM_ROUNDS round-function passes and the
// final permutation, then presents the result.
// Optional feature macro: CIPHER_DECRYPT_EN (adds in_decrypt; descending rounds).
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid/in_ready/in_data     - block input handshake
//   in_decrypt                    - decrypt mode, latched at accept (CIPHER_DECRYPT_EN only)
//   ip_set/ip_data/ip_status/ip_result - initial permutation interface
//   rnd_idx/rnd_data/rnd_result   - round function interface (combinational result)
//   fp_set/fp_data/fp_status/fp_result - final permutation interface
//   out_valid/out_ready/out_data/out_err - result handshake; out_data is 0 on error
//   state_dbg                     - current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once raised, out_valid and out_data hold until out_ready is seen.
module cipher_round_sequencer
  import cipher_pkg::*;
#(
  parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:BLOCK_W-1]   in_data,
`ifdef CIPHER_DECRYPT_EN
  input  logic                 in_decrypt,
`endif
  output logic                 ip_set,
  output logic [0:BLOCK_W-1]   ip_data,
  input  logic                 ip_status,
  input  logic [0:BLOCK_W-1]   ip_result,
  output logic [RND_IDX_W-1:0] rnd_idx,
  output logic [0:BLOCK_W-1]   rnd_data,
  input  logic [0:BLOCK_W-1]   rnd_result,
  output logic                 fp_set,
  output logic [0:BLOCK_W-1]   fp_data,
  input  logic                 fp_status,
  input  logic [0:BLOCK_W-1]   fp_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:BLOCK_W-1]   out_data,
  output logic                 out_err,
  output seq_state_t           state_dbg
);

  localparam logic [RND_IDX_W-1:0] LAST_UP = RND_IDX_W'(NUM_ROUNDS - 1);

  seq_state_t           state_q, state_d;
  logic [0:BLOCK_W-1]   work_q, work_d;
  logic [RND_IDX_W-1:0] idx_q, idx_d;
  logic                 dec_q;
  logic                 tmr_clear, tmr_en, tmr_expired;
  logic [RND_IDX_W-1:0] first_idx, last_idx;

`ifdef CIPHER_DECRYPT_EN
  logic dec_d;

  always_ff @(posedge clk) begin
    if (rst) dec_q <= 1'b0;
    else     dec_q <= dec_d;
  end
`else
  assign dec_q = 1'b0;
`endif

  // Decrypt walks the round keys backwards.
  assign first_idx = dec_q ? LAST_UP : '0;
  assign last_idx  = dec_q ? '0 : LAST_UP;

  cipher_stage_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    idx_d     = idx_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
`ifdef CIPHER_DECRYPT_EN
    dec_d     = dec_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
`ifdef CIPHER_DECRYPT_EN
          dec_d   = in_decrypt;
`endif
          state_d = S_IP_START;
        end
      end
      S_IP_START: begin
        tmr_clear = 1'b1;
        state_d   = S_IP_WAIT;
      end
      S_IP_WAIT: begin
        // A status seen on the final allowed cycle still wins over the timeout.
        if (ip_status) begin
          work_d  = ip_result;
          idx_d   = first_idx;
          state_d = S_ROUND;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) state_d = S_ERROR;
        end
      end
      S_ROUND: begin
        work_d = rnd_result;
        if (idx_q == last_idx) begin
          state_d = S_FP_START;
        end else begin
          idx_d = dec_q ? (idx_q - RND_IDX_W'(1)) : (idx_q + RND_IDX_W'(1));
        end
      end
      S_FP_START: begin
        tmr_clear = 1'b1;
        state_d   = S_FP_WAIT;
      end
      S_FP_WAIT: begin
        if (fp_status) begin
          work_d  = fp_result;
          state_d = S_DONE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) state_d = S_ERROR;
        end
      end
      S_DONE, S_ERROR: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign ip_set    = (state_q == S_IP_START);
  assign fp_set    = (state_q == S_FP_START);
  assign ip_data   = work_q;
  assign rnd_data  = work_q;
  assign fp_data   = work_q;
  assign rnd_idx   = idx_q;
  assign out_valid = (state_q == S_DONE) || (state_q == S_ERROR);
  assign out_err   = (state_q == S_ERROR);
  assign out_data  = (state_q == S_DONE) ? work_q : '0;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cipher_round_sequencer.sv
module tb_cipher_round_sequencer;
  import cipher_pkg::*;

  localparam int N  = 16;
  localparam int TO = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic         in_valid = 1'b0, in_ready, in_decrypt = 1'b0;
  logic [0:63]  in_data = '0;
  logic         ip_set, ip_status, fp_set, fp_status;
  logic [0:63]  ip_data, ip_result, rnd_data, rnd_result, fp_data, fp_result;
  logic [3:0]   rnd_idx;
  logic         out_valid, out_ready = 1'b0, out_err;
  logic [0:63]  out_data;
  seq_state_t   state_dbg;

  cipher_round_sequencer #(.NUM_ROUNDS(N), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
`ifdef CIPHER_DECRYPT_EN
    .in_decrypt (in_decrypt),
`endif
    .ip_set     (ip_set),
    .ip_data    (ip_data),
    .ip_status  (ip_status),
    .ip_result  (ip_result),
    .rnd_idx    (rnd_idx),
    .rnd_data   (rnd_data),
    .rnd_result (rnd_result),
    .fp_set     (fp_set),
    .fp_data    (fp_data),
    .fp_status  (fp_status),
    .fp_result  (fp_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .state_dbg  (state_dbg)
  );

  // ---------------- permutation / round stubs ----------------
  // Status rises 'delay' cycles after the set strobe (1 = first wait cycle, 0 = never).
  int          ip_delay = 1, fp_delay = 1, ip_cnt = 0, fp_cnt = 0;
  logic [0:63] ip_mask = '0, fp_mask = '0;
  bit          rnd_rot = 1'b0;

  always @(posedge clk) begin
    if (rst) ip_cnt <= 0;
    else if (ip_set) ip_cnt <= ip_delay;
    else if (ip_cnt > 0) ip_cnt <= ip_cnt - 1;
    if (rst) fp_cnt <= 0;
    else if (fp_set) fp_cnt <= fp_delay;
    else if (fp_cnt > 0) fp_cnt <= fp_cnt - 1;
  end

  assign ip_status  = (ip_cnt == 1);
  assign fp_status  = (fp_cnt == 1);
  assign ip_result  = ip_data ^ ip_mask;
  assign fp_result  = fp_data ^ fp_mask;
  assign rnd_result = (rnd_rot ? {rnd_data[1:63], rnd_data[0]} : rnd_data) ^ {60'h0, rnd_idx};

  // ---------------- monitors ----------------
  int         ip_pulses = 0, fp_pulses = 0;
  logic [3:0] idx_log[$];
  always @(negedge clk) begin
    if (ip_set) ip_pulses++;
    if (fp_set) fp_pulses++;
    if (state_dbg == S_ROUND) idx_log.push_back(rnd_idx);
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [0:0]  exp_err_q[$];
  logic [15:0] exp_lat_q[$];
  logic [4:0]  exp_rnds_q[$];
  logic [0:0]  exp_dec_q[$];
  logic [0:0]  exp_fpset_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cyc  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] x, input bit dec);
    logic [63:0] w;
    int          idx;
    w = x ^ ip_mask;
    for (int i = 0; i < N; i++) begin
      idx = dec ? (N - 1 - i) : i;
      if (rnd_rot) w = {w[62:0], w[63]};
      w = w ^ 64'(idx);
    end
    return w ^ fp_mask;
  endfunction

  task automatic send_block(input logic [63:0] d, input bit dec, input int ip_d, input int fp_d);
    bit dec_eff;
    int n;
`ifdef CIPHER_DECRYPT_EN
    dec_eff = dec;
`else
    dec_eff = 1'b0;
`endif
    ip_delay = ip_d;
    fp_delay = fp_d;
    if (ip_d == 0 || ip_d - 1 >= TO) begin
      exp_q.push_back(64'h0); exp_err_q.push_back(1'b1);
      exp_lat_q.push_back(16'(1 + TO)); exp_rnds_q.push_back(5'd0);
      exp_fpset_q.push_back(1'b0);
    end else if (fp_d == 0 || fp_d - 1 >= TO) begin
      exp_q.push_back(64'h0); exp_err_q.push_back(1'b1);
      exp_lat_q.push_back(16'(N + 3 + (ip_d - 1) + TO)); exp_rnds_q.push_back(5'(N));
      exp_fpset_q.push_back(1'b1);
    end else begin
      exp_q.push_back(model(d, dec_eff)); exp_err_q.push_back(1'b0);
      exp_lat_q.push_back(16'(N + 4 + (ip_d - 1) + (fp_d - 1))); exp_rnds_q.push_back(5'(N));
      exp_fpset_q.push_back(1'b1);
    end
    exp_dec_q.push_back(dec_eff);
    @(negedge clk);
    ip_pulses = 0; fp_pulses = 0; idx_log.delete();
    in_valid = 1'b1; in_data = d; in_decrypt = dec;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic drain(input int hold);
    logic [63:0] e_data;
    logic [0:0]  e_err, e_dec, e_fps;
    logic [15:0] e_lat;
    logic [4:0]  e_rnds;
    int          n, exp_idx;
    n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    e_data = exp_q.pop_front(); e_err = exp_err_q.pop_front(); e_lat = exp_lat_q.pop_front();
    e_rnds = exp_rnds_q.pop_front(); e_dec = exp_dec_q.pop_front(); e_fps = exp_fpset_q.pop_front();
    if (!out_valid) begin
      check("out_valid_timeout", 64'd0, 64'd1);
      return;
    end
    check("latency", 64'(cyc - acc_cyc), 64'(e_lat));
    check("out_data", out_data, e_data);
    check("out_err", 64'(out_err), 64'(e_err));
    check("ip_set_pulses", 64'(ip_pulses), 64'd1);
    check("fp_set_pulses", 64'(fp_pulses), 64'(e_fps));
    check("round_count", 64'(idx_log.size()), 64'(e_rnds));
    for (int i = 0; i < idx_log.size() && i < int'(e_rnds); i++) begin
      exp_idx = e_dec ? (N - 1 - i) : i;
      check("rnd_idx_seq", 64'(idx_log[i]), 64'(exp_idx));
    end
    if (hold > 0) begin
      in_valid = 1'b1;
      in_data  = 64'hdead_beef_0000_1111;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", out_data, e_data);
        check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_in_ready", 64'(in_ready), 64'd1);
    check("drain_out_valid", 64'(out_valid), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int          n;
    logic [63:0] d;
    bit          dec;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_ip_set", 64'(ip_set), 64'd0);
    check("rst_fp_set", 64'(fp_set), 64'd0);
    check("rst_rnd_idx", 64'(rnd_idx), 64'd0);
    rst = 1'b0;

    // identity permutations, XOR-only rounds: data returns unchanged
    send_block(64'h0123456789abcdef, 1'b0, 1, 1);
    drain(0);
    // delayed status on both permutations
    send_block(64'h0123456789abcdef, 1'b0, 5, 3);
    drain(0);
    // initial permutation never answers
    send_block(64'hfeedface_cafef00d, 1'b0, 0, 1);
    drain(0);
    // result held under back-pressure
    send_block(64'h1122334455667788, 1'b0, 1, 1);
    drain(10);

    // reset in the middle of the rounds
    send_block(64'h0badc0de_12345678, 1'b0, 1, 1);
    n = 0;
    while (!(state_dbg == S_ROUND && rnd_idx == 4'd7) && n < 100) begin @(negedge clk); n++; end
    check("reach_round7", 64'(rnd_idx), 64'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_rnd_idx", 64'(rnd_idx), 64'd0);
    void'(exp_q.pop_back()); void'(exp_err_q.pop_back()); void'(exp_lat_q.pop_back());
    void'(exp_rnds_q.pop_back()); void'(exp_dec_q.pop_back()); void'(exp_fpset_q.pop_back());
    send_block(64'h0123456789abcdef, 1'b0, 1, 1);
    drain(0);

    // timeout boundaries: status on the last allowed cycle, then one cycle too late
    send_block(64'h5555aaaa5555aaaa, 1'b0, TO, 1);
    drain(0);
    send_block(64'h5555aaaa5555aaaa, 1'b0, TO + 1, 1);
    drain(0);
    // final permutation never answers
    send_block(64'h0f0f0f0f0f0f0f0f, 1'b0, 2, 0);
    drain(0);

    // non-trivial data path with random blocks and delays
    rnd_rot = 1'b1;
    ip_mask = 64'ha5a5_0000_ffff_1234;
    fp_mask = 64'h0000_c3c3_5a5a_8001;
    for (int t = 0; t < 6; t++) begin
      d   = {$urandom(), $urandom()};
      dec = 1'($urandom_range(0, 1));
      send_block(d, dec, $urandom_range(1, 4), $urandom_range(1, 4));
      drain(0);
    end

`ifdef CIPHER_DECRYPT_EN
    send_block(64'h0123456789abcdef, 1'b1, 1, 1);
    drain(0);
    send_block(64'h0123456789abcdef, 1'b0, 1, 1);
    drain(0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
